// File: rtl/cmsdk_mcu_rstseq_pkg.sv
// rtl/cmsdk_mcu_rstseq_pkg.sv - shared FSM encoding and reset-cause bit indices
//
// Purpose : state encoding for the reset sequencer FSM and the bit positions
//           used in the sticky RSTCAUSE register.
// Ports   : none (package).
package cmsdk_mcu_rstseq_pkg;

  // HOLD    : HRESETn/PRESETn held low while the hold counter drains
  // STAGGER : peripheral channels released one per cycle
  // RUN     : normal operation, per-channel software resets honoured
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } rstseq_state_t;

  localparam int unsigned RSTCAUSE_W      = 3;
  localparam int unsigned RSTCAUSE_POR    = 0;
  localparam int unsigned RSTCAUSE_SYSREQ = 1;
  localparam int unsigned RSTCAUSE_LOCKUP = 2;

  // Value of the cause register straight out of power-on reset.
  function automatic logic [RSTCAUSE_W-1:0] rstcause_por_value();
    logic [RSTCAUSE_W-1:0] v;
    v = '0;
    v[RSTCAUSE_POR] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cmsdk_mcu_rst_sync.sv
// rtl/cmsdk_mcu_rst_sync.sv - 2-flop reset deassertion synchroniser
//
// Purpose : asserts its output asynchronously with rst and releases it
//           synchronously, on the 2nd clk edge after rst falls.
// Ports   : clk      - sampling clock
//           rst      - asynchronous active-high reset
//           sync_out - synchronised active-low reset (flop output)
module cmsdk_mcu_rst_sync (
  input  logic clk,
  input  logic rst,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= 1'b1;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/cmsdk_mcu_rstseq.sv
// rtl/cmsdk_mcu_rstseq.sv - MCU reset sequencer with staggered peripheral release and PCLK divider
//
// Purpose : generates power-on, system, debug and per-peripheral resets from
//           SYSRST and the core's reset requests, records the reset cause and
//           produces the PCLK enable for the AHB-to-APB bridge.
// Ports   : FCLK           - free-running clock, all logic on rising edge
//           SYSRST         - asynchronous active-high reset
//           SYSRESETREQ    - system reset request from the core
//           DBGRESETREQ    - debug reset request
//           LOCKUP         - core lockup status
//           LOCKUPRESET    - enables reset on lockup
//           PRST_REQ       - per-peripheral software reset request (level)
//           PCLKDIV        - PCLK divide ratio minus one
//           APBACTIVE      - APB transfer in progress
//           RSTCAUSE_CLR   - single-cycle clear of RSTCAUSE
//           PORESETn       - power-on reset, active low
//           HRESETn        - system/AHB reset, active low
//           DBGRESETn      - debug reset, active low
//           PRESETn        - per-channel peripheral resets, active low
//           PCLKEN         - PCLK enable (registered)
//           PCLKGEN        - gated PCLK enable, PCLKEN & APBACTIVE
//           RSTCAUSE       - sticky cause {lockup, sysresetreq, power-on}
module cmsdk_mcu_rstseq
  import cmsdk_mcu_rstseq_pkg::*;
#(
  parameter int NUM_PRST = 4,
  parameter int DIV_W    = 4,
  parameter int RST_HOLD = 16
) (
  input  logic                  FCLK,
  input  logic                  SYSRST,
  input  logic                  SYSRESETREQ,
  input  logic                  DBGRESETREQ,
  input  logic                  LOCKUP,
  input  logic                  LOCKUPRESET,
  input  logic [NUM_PRST-1:0]   PRST_REQ,
  input  logic [DIV_W-1:0]      PCLKDIV,
  input  logic                  APBACTIVE,
  input  logic                  RSTCAUSE_CLR,
  output logic                  PORESETn,
  output logic                  HRESETn,
  output logic                  DBGRESETn,
  output logic [NUM_PRST-1:0]   PRESETn,
  output logic                  PCLKEN,
  output logic                  PCLKGEN,
  output logic [RSTCAUSE_W-1:0] RSTCAUSE
);

  localparam int         CNT_W     = 8;
  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD - 1);

  rstseq_state_t         state;
  logic [CNT_W-1:0]      hold_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [DIV_W-1:0]      div_nxt;
  logic                  lock_req;
  logic                  sys_req;
  logic [NUM_PRST:0]     prst_ext;
  logic [NUM_PRST-1:0]   prst_shift;
  logic [RSTCAUSE_W-1:0] cause_set;

  // Power-on reset: deassertion synchronised to FCLK.
  cmsdk_mcu_rst_sync u_por_sync (
    .clk      (FCLK),
    .rst      (SYSRST),
    .sync_out (PORESETn)
  );

  assign lock_req = LOCKUP & LOCKUPRESET;
  assign sys_req  = SYSRESETREQ | lock_req;

  // One more channel released per cycle: shift a 1 in from channel 0.
  assign prst_ext   = {PRESETn, 1'b1};
  assign prst_shift = prst_ext[NUM_PRST-1:0];

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge FCLK or posedge SYSRST) begin
    if (SYSRST) begin
      state     <= ST_HOLD;
      hold_cnt  <= HOLD_INIT;
      HRESETn   <= 1'b0;
      DBGRESETn <= 1'b0;
      PRESETn   <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          // A request while holding restarts the full hold period.
          if (sys_req) begin
            hold_cnt <= HOLD_INIT;
          end else if (PORESETn) begin
            if (hold_cnt == '0) begin
              HRESETn   <= 1'b1;
              DBGRESETn <= 1'b1;
              PRESETn   <= NUM_PRST'(1);
              state     <= (NUM_PRST == 1) ? ST_RUN : ST_STAGGER;
            end else begin
              hold_cnt <= hold_cnt - CNT_W'(1);
            end
          end
        end

        ST_STAGGER: begin
          if (sys_req) begin
            HRESETn  <= 1'b0;
            PRESETn  <= '0;
            hold_cnt <= HOLD_INIT;
            state    <= ST_HOLD;
          end else begin
            PRESETn <= prst_shift;
            if (&prst_shift) begin
              state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          // Debug reset follows its request only once the system is running;
          // system resets leave it untouched.
          DBGRESETn <= ~DBGRESETREQ;
          if (sys_req) begin
            HRESETn  <= 1'b0;
            PRESETn  <= '0;
            hold_cnt <= HOLD_INIT;
            state    <= ST_HOLD;
          end else begin
            PRESETn <= ~PRST_REQ;
          end
        end

        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky reset cause. New causes win over a simultaneous clear.
  // ---------------------------------------------------------------------
  always_comb begin
    cause_set                  = '0;
    cause_set[RSTCAUSE_SYSREQ] = SYSRESETREQ;
    cause_set[RSTCAUSE_LOCKUP] = lock_req;
  end

  always_ff @(posedge FCLK or posedge SYSRST) begin
    if (SYSRST) begin
      RSTCAUSE <= rstcause_por_value();
    end else begin
      RSTCAUSE <= (RSTCAUSE & {RSTCAUSE_W{~RSTCAUSE_CLR}}) | cause_set;
    end
  end

  // ---------------------------------------------------------------------
  // PCLK divider. PCLKEN is registered alongside the counter so that it is
  // always equal to (div_cnt == 0); PCLKDIV is only sampled on reload.
  // ---------------------------------------------------------------------
  assign div_nxt = (div_cnt == '0) ? PCLKDIV : (div_cnt - DIV_W'(1));

  always_ff @(posedge FCLK or posedge SYSRST) begin
    if (SYSRST) begin
      div_cnt <= '0;
      PCLKEN  <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      PCLKEN  <= (div_nxt == '0);
    end
  end

  assign PCLKGEN = PCLKEN & APBACTIVE;

endmodule

// File: tb/tb_cmsdk_mcu_rstseq.sv
// tb/tb_cmsdk_mcu_rstseq.sv - directed self-checking bench for cmsdk_mcu_rstseq
module tb_cmsdk_mcu_rstseq;

  logic       FCLK = 1'b0;
  logic       SYSRST;
  logic       SYSRESETREQ;
  logic       DBGRESETREQ;
  logic       LOCKUP;
  logic       LOCKUPRESET;
  logic [3:0] PRST_REQ;
  logic [3:0] PCLKDIV;
  logic       APBACTIVE;
  logic       RSTCAUSE_CLR;
  logic       PORESETn;
  logic       HRESETn;
  logic       DBGRESETn;
  logic [3:0] PRESETn;
  logic       PCLKEN;
  logic       PCLKGEN;
  logic [2:0] RSTCAUSE;

  int n_assert = 0;
  int n_fail   = 0;

  logic [5:0] pat6;
  logic [3:0] pat4;

  always #5 FCLK = ~FCLK;

  cmsdk_mcu_rstseq #(
    .NUM_PRST (4),
    .DIV_W    (4),
    .RST_HOLD (4)
  ) dut (
    .FCLK         (FCLK),
    .SYSRST       (SYSRST),
    .SYSRESETREQ  (SYSRESETREQ),
    .DBGRESETREQ  (DBGRESETREQ),
    .LOCKUP       (LOCKUP),
    .LOCKUPRESET  (LOCKUPRESET),
    .PRST_REQ     (PRST_REQ),
    .PCLKDIV      (PCLKDIV),
    .APBACTIVE    (APBACTIVE),
    .RSTCAUSE_CLR (RSTCAUSE_CLR),
    .PORESETn     (PORESETn),
    .HRESETn      (HRESETn),
    .DBGRESETn    (DBGRESETn),
    .PRESETn      (PRESETn),
    .PCLKEN       (PCLKEN),
    .PCLKGEN      (PCLKGEN),
    .RSTCAUSE     (RSTCAUSE)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge FCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    SYSRST       = 1'b1;
    SYSRESETREQ  = 1'b0;
    DBGRESETREQ  = 1'b0;
    LOCKUP       = 1'b0;
    LOCKUPRESET  = 1'b0;
    PRST_REQ     = 4'b0000;
    PCLKDIV      = 4'd0;
    APBACTIVE    = 1'b1;
    RSTCAUSE_CLR = 1'b0;

    // Reset state
    tick(2);
    chk("rst_poresetn", 32'(PORESETn), 32'h0);
    chk("rst_hresetn", 32'(HRESETn), 32'h0);
    chk("rst_dbgresetn", 32'(DBGRESETn), 32'h0);
    chk("rst_presetn", 32'(PRESETn), 32'h0);
    chk("rst_pclken", 32'(PCLKEN), 32'h1);
    chk("rst_rstcause", 32'(RSTCAUSE), 32'h1);

    // Power-on release sequence
    SYSRST = 1'b0;
    tick(1);
    chk("por_edge1", 32'(PORESETn), 32'h0);
    tick(1);
    chk("por_edge2", 32'(PORESETn), 32'h1);
    chk("por_edge2_hrst", 32'(HRESETn), 32'h0);
    tick(3);
    chk("por_edge5_hrst", 32'(HRESETn), 32'h0);
    chk("por_edge5_prst", 32'(PRESETn), 32'h0);
    tick(1);
    chk("por_edge6_hrst", 32'(HRESETn), 32'h1);
    chk("por_edge6_dbg", 32'(DBGRESETn), 32'h1);
    chk("por_edge6_prst", 32'(PRESETn), 32'h1);
    tick(1);
    chk("por_edge7_prst", 32'(PRESETn), 32'h3);
    tick(1);
    chk("por_edge8_prst", 32'(PRESETn), 32'h7);
    tick(1);
    chk("por_edge9_prst", 32'(PRESETn), 32'hF);
    chk("por_cause", 32'(RSTCAUSE), 32'h1);

    // SYSRESETREQ in RUN
    SYSRESETREQ = 1'b1;
    tick(1);
    SYSRESETREQ = 1'b0;
    chk("sys_hrst_low", 32'(HRESETn), 32'h0);
    chk("sys_prst_low", 32'(PRESETn), 32'h0);
    chk("sys_dbg_high", 32'(DBGRESETn), 32'h1);
    chk("sys_cause", 32'(RSTCAUSE), 32'h3);
    tick(3);
    chk("sys_hold3", 32'(HRESETn), 32'h0);
    tick(1);
    chk("sys_rel_hrst", 32'(HRESETn), 32'h1);
    chk("sys_rel_prst", 32'(PRESETn), 32'h1);
    tick(3);
    chk("sys_rel_all", 32'(PRESETn), 32'hF);
    chk("sys_dbg_still", 32'(DBGRESETn), 32'h1);

    // Per-channel software reset, one cycle delayed
    PRST_REQ = 4'b0100;
    tick(1);
    chk("prst_c1", 32'(PRESETn), 32'hB);
    tick(2);
    chk("prst_c3", 32'(PRESETn), 32'hB);
    PRST_REQ = 4'b0000;
    tick(1);
    chk("prst_c4", 32'(PRESETn), 32'hF);

    // Debug reset request
    DBGRESETREQ = 1'b1;
    tick(1);
    chk("dbg_low", 32'(DBGRESETn), 32'h0);
    chk("dbg_hrst", 32'(HRESETn), 32'h1);
    DBGRESETREQ = 1'b0;
    tick(1);
    chk("dbg_high", 32'(DBGRESETn), 32'h1);

    // Divider: PCLKDIV=2 -> every 3rd cycle
    PCLKDIV = 4'd2;
    pat6 = '0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      pat6 = {pat6[4:0], PCLKEN};
    end
    chk("div3_pattern", 32'(pat6), 32'h09);
    tick(1);
    chk("div3_reload", 32'(PCLKEN), 32'h0);
    // Change to 0 mid-count: takes effect only after the next pulse
    PCLKDIV = 4'd0;
    pat4 = '0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      pat4 = {pat4[2:0], PCLKEN};
    end
    chk("div_change", 32'(pat4), 32'h7);
    APBACTIVE = 1'b0;
    #1;
    chk("pclkgen_off", 32'(PCLKGEN), 32'h0);
    APBACTIVE = 1'b1;
    #1;
    chk("pclkgen_on", 32'(PCLKGEN), 32'h1);

    // Lockup without lockup-reset enable: no reset
    LOCKUP = 1'b1;
    tick(2);
    chk("lock_noen_hrst", 32'(HRESETn), 32'h1);
    chk("lock_noen_cause", 32'(RSTCAUSE), 32'h3);
    RSTCAUSE_CLR = 1'b1;
    tick(1);
    RSTCAUSE_CLR = 1'b0;
    chk("cause_clr", 32'(RSTCAUSE), 32'h0);
    LOCKUPRESET = 1'b1;
    tick(1);
    chk("lock_hrst", 32'(HRESETn), 32'h0);
    chk("lock_prst", 32'(PRESETn), 32'h0);
    chk("lock_cause", 32'(RSTCAUSE), 32'h4);
    LOCKUP = 1'b0;
    LOCKUPRESET = 1'b0;
    tick(3);
    chk("lock_hold", 32'(HRESETn), 32'h0);
    tick(1);
    chk("lock_rel", 32'(HRESETn), 32'h1);
    tick(3);
    chk("lock_rel_all", 32'(PRESETn), 32'hF);

    // Clear together with a new request: new bit stays set
    RSTCAUSE_CLR = 1'b1;
    SYSRESETREQ  = 1'b1;
    tick(1);
    RSTCAUSE_CLR = 1'b0;
    SYSRESETREQ  = 1'b0;
    chk("clr_and_set", 32'(RSTCAUSE), 32'h2);

    // Request during STAGGER, then during HOLD
    tick(3);
    chk("stg_hold", 32'(HRESETn), 32'h0);
    tick(1);
    chk("stg_rel", 32'(PRESETn), 32'h1);
    tick(1);
    chk("stg_two", 32'(PRESETn), 32'h3);
    SYSRESETREQ = 1'b1;
    tick(1);
    SYSRESETREQ = 1'b0;
    chk("stg_abort_prst", 32'(PRESETn), 32'h0);
    chk("stg_abort_hrst", 32'(HRESETn), 32'h0);
    tick(2);
    SYSRESETREQ = 1'b1;
    tick(1);
    SYSRESETREQ = 1'b0;
    tick(3);
    chk("hold_reload", 32'(HRESETn), 32'h0);
    tick(1);
    chk("hold_reload_rel", 32'(HRESETn), 32'h1);
    tick(3);
    chk("hold_reload_all", 32'(PRESETn), 32'hF);

    // SYSRST asserted mid-run aborts immediately
    SYSRST = 1'b1;
    #1;
    chk("abort_por", 32'(PORESETn), 32'h0);
    chk("abort_hrst", 32'(HRESETn), 32'h0);
    chk("abort_dbg", 32'(DBGRESETn), 32'h0);
    chk("abort_prst", 32'(PRESETn), 32'h0);
    chk("abort_cause", 32'(RSTCAUSE), 32'h1);
    #2;
    SYSRST = 1'b0;
    tick(1);
    chk("restart_edge1", 32'(PORESETn), 32'h0);
    tick(1);
    chk("restart_edge2", 32'(PORESETn), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
